// File: rtl/ps2_key_receiver.sv
// -----------------------------------------------------------------------------
// ps2_key_receiver
//
// Purpose:
//   Decodes the PS/2 keyboard serial line into 8-bit scan codes for the
//   Pac-Man direction controller. Each key-press (make) event produces a
//   one-cycle ps2_ready strobe together with the scan code and a flag telling
//   whether the code was E0-prefixed (arrow keys: E0 6B/74/75/72). E0 and F0
//   prefix bytes are consumed internally; break (release) sequences never
//   strobe. Malformed frames and stalled frames raise a one-cycle frame_err.
//
// Ports:
//   clk           in   1  system clock
//   rst           in   1  synchronous reset, active-high
//   ps2_clk       in   1  raw PS/2 clock pin, asynchronous
//   ps2_data      in   1  raw PS/2 data pin, asynchronous
//   keyboardCode  out  8  last accepted make code
//   ps2_ready     out  1  one-cycle strobe: new make code valid
//   ps2_extended  out  1  1 if last make code was E0-prefixed
//   frame_err     out  1  one-cycle strobe on start/parity/stop error/timeout
//
// Parameters:
//   FILTER_LEN      consecutive equal synchronized ps2_clk samples needed
//                   before the filtered clock changes level
//   TIMEOUT_CYCLES  idle clk cycles inside a frame before it is aborted
//
// Optional feature (macro PS2_TYPEMATIC_FILTER_EN):
//   When defined, auto-repeat make codes of the key currently held down are
//   suppressed until a matching break sequence is seen. When undefined every
//   make event strobes, including typematic repeats.
// -----------------------------------------------------------------------------
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboardCode,
  output logic       ps2_ready,
  output logic       ps2_extended,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_DECODE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: synchronizers, clock glitch filter, falling-edge detect
  // ---------------------------------------------------------------------------
  logic          r_clk_meta, r_clk_sync;
  logic          r_data_meta, r_data_sync;
  logic          r_filt_clk, r_filt_clk_d;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fe;

  // Lines idle high, so the synchronizers and the filter reset to 1; this
  // keeps a reset from looking like a falling clock edge.
  // NOTE: sequential state is written only with non-blocking (<=)
  // assignments so every flop samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta   <= 1'b1;
      r_clk_sync   <= 1'b1;
      r_data_meta  <= 1'b1;
      r_data_sync  <= 1'b1;
      r_filt_clk   <= 1'b1;
      r_filt_clk_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_meta   <= ps2_clk;
      r_clk_sync   <= r_clk_meta;
      r_data_meta  <= ps2_data;
      r_data_sync  <= r_data_meta;
      r_filt_clk_d <= r_filt_clk;
      // Count consecutive samples that disagree with the filtered level;
      // any agreeing sample restarts the count, so short glitches vanish.
      if (r_clk_sync == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_sync;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fe = r_filt_clk_d & ~r_filt_clk;

  // ---------------------------------------------------------------------------
  // Frame FSM and decode state
  // ---------------------------------------------------------------------------
  state_t        r_state, w_state_nx;
  logic [3:0]    r_bitcnt, w_bitcnt_nx;
  // Bits after the start bit, shifted in from the top: after ten shifts
  // [7:0]=D7..D0, [8]=parity, [9]=stop.
  logic [9:0]    r_shift, w_shift_nx;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nx;
  logic          r_ext_pend, w_ext_pend_nx;
  logic          r_brk_pend, w_brk_pend_nx;
  logic [7:0]    r_code, w_code_nx;
  logic          r_ext, w_ext_nx;
  logic          w_ready;
  logic          w_err;
  logic [7:0]    w_byte;
  logic          w_frame_ok;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic          r_held_valid, w_held_valid_nx;
  logic [8:0]    r_held_key,   w_held_key_nx;
  logic          w_is_held;
`endif

  assign w_byte     = r_shift[7:0];
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign w_frame_ok = (^r_shift[8:0]) & r_shift[9];

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign w_is_held = r_held_valid && (r_held_key == {r_ext_pend, w_byte});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_code     <= 8'h00;
      r_ext      <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_held_valid <= 1'b0;
      r_held_key   <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_bitcnt   <= w_bitcnt_nx;
      r_shift    <= w_shift_nx;
      r_to_cnt   <= w_to_cnt_nx;
      r_ext_pend <= w_ext_pend_nx;
      r_brk_pend <= w_brk_pend_nx;
      r_code     <= w_code_nx;
      r_ext      <= w_ext_nx;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_held_valid <= w_held_valid_nx;
      r_held_key   <= w_held_key_nx;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_state_nx    = r_state;
    w_bitcnt_nx   = r_bitcnt;
    w_shift_nx    = r_shift;
    w_to_cnt_nx   = r_to_cnt;
    w_ext_pend_nx = r_ext_pend;
    w_brk_pend_nx = r_brk_pend;
    w_code_nx     = r_code;
    w_ext_nx      = r_ext;
    w_ready       = 1'b0;
    w_err         = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    w_held_valid_nx = r_held_valid;
    w_held_key_nx   = r_held_key;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_to_cnt_nx = '0;
        w_bitcnt_nx = '0;
        if (w_fe) begin
          if (!r_data_sync) begin
            w_state_nx  = S_RECV;
            w_bitcnt_nx = 4'd1;
          end else begin
            // A clock edge with data high cannot be a start bit.
            w_err = 1'b1;
          end
        end
      end

      S_RECV: begin
        if (w_fe) begin
          w_shift_nx  = {r_data_sync, r_shift[9:1]};
          w_bitcnt_nx = r_bitcnt + 4'd1;
          w_to_cnt_nx = '0;
          if (r_bitcnt == 4'd10) begin
            w_state_nx  = S_CHECK;
            w_bitcnt_nx = '0;
          end
        end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          // Keyboard stopped clocking mid-frame: abandon the byte and any
          // prefix context, since the sequence it belonged to is lost.
          w_state_nx    = S_IDLE;
          w_err         = 1'b1;
          w_ext_pend_nx = 1'b0;
          w_brk_pend_nx = 1'b0;
          w_to_cnt_nx   = '0;
          w_bitcnt_nx   = '0;
        end else begin
          w_to_cnt_nx = r_to_cnt + 1'b1;
        end
      end

      S_CHECK: begin
        if (w_frame_ok) begin
          w_state_nx = S_DECODE;
        end else begin
          w_state_nx    = S_IDLE;
          w_err         = 1'b1;
          w_ext_pend_nx = 1'b0;
          w_brk_pend_nx = 1'b0;
        end
      end

      S_DECODE: begin
        w_state_nx = S_IDLE;
        if (w_byte == BYTE_EXT) begin
          w_ext_pend_nx = 1'b1;
        end else if (w_byte == BYTE_BREAK) begin
          w_brk_pend_nx = 1'b1;
        end else if (w_byte == BYTE_PAUSE) begin
          // Pause sequence prefix: not used by the controller, drop it.
        end else if (r_brk_pend) begin
          // Release of a key: closes the sequence, never strobes.
          w_ext_pend_nx = 1'b0;
          w_brk_pend_nx = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (w_is_held) begin
            w_held_valid_nx = 1'b0;
          end
`endif
        end else begin
          w_ext_pend_nx = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          // Auto-repeat of the key already held down is swallowed.
          if (!w_is_held) begin
            w_code_nx       = w_byte;
            w_ext_nx        = r_ext_pend;
            w_ready         = 1'b1;
            w_held_valid_nx = 1'b1;
            w_held_key_nx   = {r_ext_pend, w_byte};
          end
`else
          w_code_nx = w_byte;
          w_ext_nx  = r_ext_pend;
          w_ready   = 1'b1;
`endif
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // The code/extended outputs present the value being loaded, so they change
  // in the same cycle as the ready strobe and then hold in r_code/r_ext.
  // All outputs are functions of registers only; no pin reaches them
  // combinationally.
  assign keyboardCode = w_code_nx;
  assign ps2_extended = w_ext_nx;
  assign ps2_ready    = w_ready;
  assign frame_err    = w_err;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_receiver
//
// Purpose:
//   Self-checking bench for ps2_key_receiver. Stimulus pushes the expected
//   ready/error events into a queue before sending each PS/2 frame; a monitor
//   on the falling system clock pops and compares whenever the DUT strobes
//   ps2_ready or frame_err. Any strobe with nothing expected is an error.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboardCode;
  logic       ps2_ready;
  logic       ps2_extended;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_ready = 1'b0;

  ps2_key_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keyboardCode(keyboardCode),
    .ps2_ready   (ps2_ready),
    .ps2_extended(ps2_extended),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ready(input logic [7:0] code, input logic ext);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = code;
    e.ext    = ext;
    q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    e.ext    = 1'b0;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends the first nbits of a frame: start, D0..D7, parity, stop.
  // Data changes mid-way through the clock-high phase; optionally a 3-cycle
  // low glitch is injected on ps2_clk during the high phase after bit 3.
  task automatic send_frame(input logic [7:0] b, input bit par_flip,
                            input bit stop_v, input int nbits,
                            input bit glitch);
    logic [10:0] f;
    logic        par;
    par = (~^b) ^ par_flip;
    f   = {stop_v, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cycles(20);
      ps2_clk = 1'b0;
      cycles(40);
      ps2_clk = 1'b1;
      cycles(20);
      if (glitch && i == 3) begin
        cycles(5);
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(20);
      end
    end
    ps2_data = 1'b1;
    cycles(40);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] code,
                               input logic ext);
    @(negedge clk);
    check({tag, "_code"}, {24'h0, keyboardCode}, {24'h0, code});
    check({tag, "_ext"},  {31'h0, ps2_extended}, {31'h0, ext});
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (ps2_ready || frame_err)) begin
      exp_t e;
      check("ready_err_exclusive", {31'h0, ps2_ready & frame_err}, 32'h0);
      check("ready_one_cycle", {31'h0, ps2_ready & prev_ready}, 32'h0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got ready=%0b err=%0b code=%0h expected no event",
                 ps2_ready, frame_err, keyboardCode);
      end else begin
        e = q.pop_front();
        check("event_kind_err", {31'h0, frame_err}, {31'h0, e.is_err});
        if (!e.is_err) begin
          check("event_code", {24'h0, keyboardCode}, {24'h0, e.code});
          check("event_ext",  {31'h0, ps2_extended}, {31'h0, e.ext});
        end
      end
    end
    prev_ready <= ps2_ready;
  end

  initial begin
    // Reset state
    cycles(5);
    @(negedge clk);
    check("rst_code",  {24'h0, keyboardCode}, 32'h0);
    check("rst_ext",   {31'h0, ps2_extended}, 32'h0);
    check("rst_ready", {31'h0, ps2_ready},    32'h0);
    check("rst_err",   {31'h0, frame_err},    32'h0);
    rst = 1'b0;
    cycles(20);

    // Plain make code
    expect_ready(8'h1C, 1'b0);
    send_byte(8'h1C);

    // Extended make (left arrow), then its break: no strobe, outputs hold
    expect_ready(8'h6B, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h6B);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check_outputs("after_break", 8'h6B, 1'b1);

    // Parity error, then a good frame
    expect_err();
    send_frame(8'h74, 1'b1, 1'b1, 11, 1'b0);
    check_outputs("after_parity_err", 8'h6B, 1'b1);
    expect_ready(8'h75, 1'b0);
    send_byte(8'h75);

    // Stalled frame: start + 4 data bits, then silence past the timeout
    expect_err();
    send_frame(8'h72, 1'b0, 1'b1, 5, 1'b0);
    cycles(TIMEOUT_CYCLES + 100);
    expect_ready(8'h72, 1'b0);
    send_byte(8'h72);

    // Short clock glitches: in idle, and inside a frame
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(40);
    expect_ready(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);

    // Bad stop bit, and a clock edge in idle with data high
    expect_err();
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    expect_err();
    ps2_data = 1'b1;
    cycles(20);
    ps2_clk = 1'b0;
    cycles(40);
    ps2_clk = 1'b1;
    cycles(40);
    check_outputs("after_errs", 8'h1C, 1'b0);

    // Reset mid-frame with an E0 prefix pending
    send_byte(8'hE0);
    send_frame(8'h74, 1'b0, 1'b1, 4, 1'b0);
    rst = 1'b1;
    cycles(2);
    @(negedge clk);
    check("midrst_code",  {24'h0, keyboardCode}, 32'h0);
    check("midrst_ext",   {31'h0, ps2_extended}, 32'h0);
    check("midrst_ready", {31'h0, ps2_ready},    32'h0);
    check("midrst_err",   {31'h0, frame_err},    32'h0);
    rst = 1'b0;
    cycles(20);
    expect_ready(8'h74, 1'b0);
    send_byte(8'h74);

    // Typematic repeats of the right arrow, release, press again
`ifdef PS2_TYPEMATIC_FILTER_EN
    expect_ready(8'h75, 1'b1);
`else
    expect_ready(8'h75, 1'b1);
    expect_ready(8'h75, 1'b1);
    expect_ready(8'h75, 1'b1);
`endif
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hE0);
      send_byte(8'h75);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    expect_ready(8'h75, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h75);
    check_outputs("final", 8'h75, 1'b1);

    cycles(200);
    check("queue_drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
